// File: rtl/load_store_unit.sv
// ============================================================================
//  Module      : load_store_unit
//  Description : Memory-access stage in front of a word-organised data memory
//                with a one-cycle registered read. Accepts one load/store at a
//                time over a valid/ready handshake, performs byte stores as
//                read-modify-write, and returns a one-cycle response pulse.
//  Ports       : clk, rst                       - clock, sync active-high reset
//                reqValid/reqReady              - request handshake
//                reqWrite/reqByte/reqSigned     - access kind
//                reqAddr, reqData               - byte address, store data
//                respValid/respError/respData   - completion pulse and result
//                memAddress/memWriteEnable/
//                memWriteData/memData           - data-memory port
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_store_unit #(
    parameter int WORDS_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reqValid,
    output logic                  reqReady,
    input  logic                  reqWrite,
    input  logic                  reqByte,
    input  logic                  reqSigned,
    input  logic [WORDS_LOG2+1:0] reqAddr,
    input  logic [31:0]           reqData,
    output logic                  respValid,
    output logic                  respError,
    output logic [31:0]           respData,
    output logic [WORDS_LOG2-1:0] memAddress,
    output logic                  memWriteEnable,
    output logic [31:0]           memWriteData,
    input  logic [31:0]           memData
);

    // MERGE doubles as the capture cycle of a load (memData valid there).
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_MERGE = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]            r_state,       w_state;
    logic                  r_write,       w_write;
    logic                  r_byte,        w_byte;
    logic                  r_signed,      w_signed;
    logic [1:0]            r_lane,        w_lane;
    logic [7:0]            r_data_byte,   w_data_byte;
    logic                  r_resp_valid,  w_resp_valid;
    logic                  r_resp_error,  w_resp_error;
    logic [31:0]           r_resp_data,   w_resp_data;
    logic [WORDS_LOG2-1:0] r_mem_addr,    w_mem_addr;
    logic                  r_mem_we,      w_mem_we;
    logic [31:0]           r_mem_wdata,   w_mem_wdata;

    logic [7:0]            w_rd_byte;
    logic [31:0]           w_load_val;
    logic [31:0]           w_merged;

    // Selected little-endian lane of the word returned by the memory.
    assign w_rd_byte  = memData[{r_lane, 3'b000} +: 8];
    assign w_load_val = r_byte ? {{24{r_signed & w_rd_byte[7]}}, w_rd_byte} : memData;

    always_comb begin
        w_merged = memData;
        w_merged[{r_lane, 3'b000} +: 8] = r_data_byte;
    end

    always_comb begin
        w_state      = r_state;
        w_write      = r_write;
        w_byte       = r_byte;
        w_signed     = r_signed;
        w_lane       = r_lane;
        w_data_byte  = r_data_byte;
        w_resp_valid = 1'b0;
        w_resp_error = r_resp_error;
        w_resp_data  = r_resp_data;
        w_mem_addr   = r_mem_addr;
        w_mem_we     = 1'b0;
        w_mem_wdata  = r_mem_wdata;
        case (r_state)
            S_IDLE: begin
                if (reqValid) begin
                    w_write     = reqWrite;
                    w_byte      = reqByte;
                    w_signed    = reqSigned;
                    w_lane      = reqAddr[1:0];
                    w_data_byte = reqData[7:0];
                    if (!reqByte && (reqAddr[1:0] != 2'b00)) begin
                        // Misaligned word access: answer immediately, memory untouched.
                        w_state      = S_DONE;
                        w_resp_valid = 1'b1;
                        w_resp_error = 1'b1;
                    end else if (reqWrite && !reqByte) begin
                        w_state      = S_WRITE;
                        w_resp_error = 1'b0;
                        w_mem_addr   = reqAddr[WORDS_LOG2+1:2];
                        w_mem_wdata  = reqData;
                        w_mem_we     = 1'b1;
                    end else begin
                        w_state      = S_READ;
                        w_resp_error = 1'b0;
                        w_mem_addr   = reqAddr[WORDS_LOG2+1:2];
                    end
                end
            end
            S_READ: begin
                w_state = S_MERGE;
            end
            S_MERGE: begin
                if (r_write) begin
                    w_state     = S_WRITE;
                    w_mem_wdata = w_merged;
                    w_mem_we    = 1'b1;
                end else begin
                    w_state      = S_DONE;
                    w_resp_data  = w_load_val;
                    w_resp_valid = 1'b1;
                end
            end
            S_WRITE: begin
                w_state      = S_DONE;
                w_resp_valid = 1'b1;
            end
            S_DONE: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_write      <= 1'b0;
            r_byte       <= 1'b0;
            r_signed     <= 1'b0;
            r_lane       <= 2'b00;
            r_data_byte  <= 8'h00;
            r_resp_valid <= 1'b0;
            r_resp_error <= 1'b0;
            r_resp_data  <= 32'h0;
            r_mem_addr   <= '0;
            r_mem_we     <= 1'b0;
            r_mem_wdata  <= 32'h0;
        end else begin
            r_state      <= w_state;
            r_write      <= w_write;
            r_byte       <= w_byte;
            r_signed     <= w_signed;
            r_lane       <= w_lane;
            r_data_byte  <= w_data_byte;
            r_resp_valid <= w_resp_valid;
            r_resp_error <= w_resp_error;
            r_resp_data  <= w_resp_data;
            r_mem_addr   <= w_mem_addr;
            r_mem_we     <= w_mem_we;
            r_mem_wdata  <= w_mem_wdata;
        end
    end

    assign reqReady       = (r_state == S_IDLE) && !rst;
    assign respValid      = r_resp_valid;
    assign respError      = r_resp_error;
    assign respData       = r_resp_data;
    assign memAddress     = r_mem_addr;
    // Reset arriving during WRITE must suppress the write in that same cycle.
    assign memWriteEnable = r_mem_we & ~rst;
    assign memWriteData   = r_mem_wdata;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
//  Module      : tb_load_store_unit
//  Description : Scoreboard bench for load_store_unit with a behavioural
//                16-word memory (registered read, negedge write).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic        reqWrite = 1'b0;
    logic        reqByte = 1'b0;
    logic        reqSigned = 1'b0;
    logic [5:0]  reqAddr = 6'h0;
    logic [31:0] reqData = 32'h0;
    logic        respValid;
    logic        respError;
    logic [31:0] respData;
    logic [3:0]  memAddress;
    logic        memWriteEnable;
    logic [31:0] memWriteData;
    logic [31:0] memData;

    load_store_unit #(.WORDS_LOG2(4)) dut (
        .clk(clk), .rst(rst),
        .reqValid(reqValid), .reqReady(reqReady),
        .reqWrite(reqWrite), .reqByte(reqByte), .reqSigned(reqSigned),
        .reqAddr(reqAddr), .reqData(reqData),
        .respValid(respValid), .respError(respError), .respData(respData),
        .memAddress(memAddress), .memWriteEnable(memWriteEnable),
        .memWriteData(memWriteData), .memData(memData)
    );

    always #5 clk = ~clk;

    // Behavioural data memory
    logic [31:0] mem [16] = '{default: 32'h0};
    logic [31:0] mem_rdata = 32'h0;
    int          we_count = 0;
    logic [3:0]  last_we_addr = 4'h0;
    assign memData = mem_rdata;
    always @(posedge clk) mem_rdata <= mem[memAddress];
    always @(negedge clk) begin
        if (memWriteEnable) begin
            mem[memAddress] = memWriteData;
            last_we_addr = memAddress;
            we_count++;
        end
    end

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        string       name;
        logic        err;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_err = 0;
    int          resp_count = 0;
    logic [31:0] last_rd = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
        end
    endtask

    // Monitor: pops one expectation per response pulse
    always @(negedge clk) begin
        if (!rst && respValid) begin
            resp_count++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_resp: got respValid=1 at cycle %0d, required no response", cyc_cnt);
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.name, "_err"},   {31'h0, respError}, {31'h0, mon_e.err});
                check({mon_e.name, "_data"},  respData, mon_e.data);
                check({mon_e.name, "_cycle"}, 32'(cyc_cnt), 32'(mon_e.cyc));
            end
        end
    end

    // Presents a request and leaves reqValid high; the caller drops it.
    task automatic issue(input string name, input logic wr, input logic by, input logic sg,
                         input logic [5:0] addr, input logic [31:0] data, input int lat,
                         input logic err, input logic is_load, input logic [31:0] ld_val,
                         input logic want_resp);
        exp_t e;
        int   guard;
        @(negedge clk);
        reqValid  = 1'b1;
        reqWrite  = wr;
        reqByte   = by;
        reqSigned = sg;
        reqAddr   = addr;
        reqData   = data;
        guard = 0;
        while (!reqReady && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!reqReady) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_accept: got reqReady=0 for 100 cycles, required 1", name);
            reqValid = 1'b0;
            return;
        end
        if (is_load && !err) last_rd = ld_val;
        e.name = name;
        e.err  = err;
        e.data = last_rd;
        e.cyc  = cyc_cnt + lat;
        if (want_resp) exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while (exp_q.size() != 0 && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_drain: got %0d responses outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        @(negedge clk);
    endtask

    int wc0;
    int rc0;

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready",  {31'h0, reqReady},       32'h0);
        check("rst_rvalid", {31'h0, respValid},      32'h0);
        check("rst_rerror", {31'h0, respError},      32'h0);
        check("rst_rdata",  respData,                32'h0);
        check("rst_maddr",  {28'h0, memAddress},     32'h0);
        check("rst_mwe",    {31'h0, memWriteEnable}, 32'h0);
        check("rst_mwdata", memWriteData,            32'h0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", {31'h0, reqReady}, 32'h1);

        // Word store then word load
        issue("st_w08", 1, 0, 0, 6'h08, 32'hDEADBEEF, 2, 0, 0, 0, 1);
        reqValid = 1'b0;
        @(negedge clk);
        check("st_w08_we",    {31'h0, memWriteEnable}, 32'h1);
        check("st_w08_maddr", {28'h0, memAddress},     32'h2);
        check("st_w08_wdata", memWriteData,            32'hDEADBEEF);
        drain("st_w08");
        check("st_w08_mem", mem[2], 32'hDEADBEEF);
        issue("ld_w08", 0, 0, 0, 6'h08, 0, 3, 0, 1, 32'hDEADBEEF, 1);
        reqValid = 1'b0;
        drain("ld_w08");

        // Byte store read-modify-write
        issue("st_w08b", 1, 0, 0, 6'h08, 32'h11223344, 2, 0, 0, 0, 1);
        reqValid = 1'b0;
        drain("st_w08b");
        wc0 = we_count;
        issue("st_b09", 1, 1, 0, 6'h09, 32'h000000AA, 4, 0, 0, 0, 1);
        reqValid = 1'b0;
        drain("st_b09");
        check("st_b09_we_pulses", 32'(we_count - wc0), 32'h1);
        check("st_b09_we_addr",   {28'h0, last_we_addr}, 32'h2);
        issue("ld_w08m", 0, 0, 0, 6'h08, 0, 3, 0, 1, 32'h1122AA44, 1);
        reqValid = 1'b0;
        drain("ld_w08m");

        // Byte load extension
        issue("st_w0c", 1, 0, 0, 6'h0C, 32'h80FF7F01, 2, 0, 0, 0, 1);
        reqValid = 1'b0;
        drain("st_w0c");
        issue("ld_b0e_s", 0, 1, 1, 6'h0E, 0, 3, 0, 1, 32'hFFFFFFFF, 1);
        issue("ld_b0f_u", 0, 1, 0, 6'h0F, 0, 3, 0, 1, 32'h00000080, 1);
        issue("ld_b0f_s", 0, 1, 1, 6'h0F, 0, 3, 0, 1, 32'hFFFFFF80, 1);
        issue("ld_b0d_s", 0, 1, 1, 6'h0D, 0, 3, 0, 1, 32'h0000007F, 1);
        issue("ld_b0c_u", 0, 1, 0, 6'h0C, 0, 3, 0, 1, 32'h00000001, 1);
        reqValid = 1'b0;
        drain("ld_bytes");

        // Misaligned word accesses
        wc0 = we_count;
        issue("ld_w05_mis", 0, 0, 0, 6'h05, 0, 1, 1, 1, 0, 1);
        reqValid = 1'b0;
        drain("ld_w05_mis");
        issue("st_w06_mis", 1, 0, 0, 6'h06, 32'h55555555, 1, 1, 0, 0, 1);
        reqValid = 1'b0;
        drain("st_w06_mis");
        check("mis_no_write", 32'(we_count - wc0), 32'h0);

        // Top of address range: bytes 60..63 live in word 15
        issue("st_b3f", 1, 1, 0, 6'h3F, 32'h0000005A, 4, 0, 0, 0, 1);
        reqValid = 1'b0;
        drain("st_b3f");
        issue("ld_w3c", 0, 0, 0, 6'h3C, 0, 3, 0, 1, 32'h5A000000, 1);
        reqValid = 1'b0;
        drain("ld_w3c");

        // Reset during WRITE aborts the store
        wc0 = we_count;
        rc0 = resp_count;
        issue("st_w10_abort", 1, 0, 0, 6'h10, 32'h12345678, 2, 0, 0, 0, 0);
        reqValid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_rd = 32'h0;
        @(negedge clk);
        check("abort_ready", {31'h0, reqReady}, 32'h1);
        repeat (4) @(negedge clk);
        check("abort_mem4",    mem[4],                    32'h0);
        check("abort_no_we",   32'(we_count - wc0),       32'h0);
        check("abort_no_resp", 32'(resp_count - rc0),     32'h0);
        check("abort_rdata",   respData,                  32'h0);

        // reqValid held high across three queued requests
        rc0 = resp_count;
        issue("q_st_w14", 1, 0, 0, 6'h14, 32'hCAFEF00D, 2, 0, 0, 0, 1);
        issue("q_ld_w14", 0, 0, 0, 6'h14, 0, 3, 0, 1, 32'hCAFEF00D, 1);
        issue("q_ld_b15", 0, 1, 0, 6'h15, 0, 3, 0, 1, 32'h000000F0, 1);
        reqValid = 1'b0;
        drain("queued");
        repeat (6) @(negedge clk);
        check("queued_resp_count", 32'(resp_count - rc0), 32'h3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got simulation still running, required completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Memory-access stage sitting directly upstream of the 16-word data memory. It accepts one load or store request at a time from the execute stage over a valid/ready handshake and drives the memory's word address, write enable and write data. It sequences the memory's one-cycle registered read, and performs byte stores as read-modify-write because the memory only writes whole words. Results return on a single-cycle response pulse.

## Interface
- WORDS_LOG2, 4, word-address width toward the data memory; byte address width is WORDS_LOG2+2 (6 bits at default)
- clk  in  1  single clock; all state changes on posedge
- rst  in  1  synchronous, active-high reset
- reqValid  in  1  request present
- reqReady  out  1  unit idle and able to accept; transfer when reqValid && reqReady at a posedge
- reqWrite  in  1  1 = store, 0 = load
- reqByte  in  1  1 = byte access, 0 = word access
- reqSigned  in  1  byte load only: 1 = sign-extend, 0 = zero-extend
- reqAddr  in  WORDS_LOG2+2  byte address
- reqData  in  32  store data; byte store uses bits [7:0]
- respValid  out  1  one-cycle completion pulse
- respError  out  1  qualified by respValid; misaligned word access
- respData  out  32  load result, valid when respValid && !reqWrite of the completed request
- memAddress  out  WORDS_LOG2  to memory address
- memWriteEnable  out  1  to memory write enable
- memWriteData  out  32  to memory write data
- memData  in  32  from memory read data, valid the cycle after the address was presented

## Operation
- States: IDLE, READ, MERGE, WRITE, DONE. Fields latched on acceptance: write, byte, signed, addr, data.
- IDLE: reqReady=1. On acceptance:
  - word access with reqAddr[1:0]!=0 goes to DONE with respError=1; no memory access.
  - word store goes to WRITE.
  - load or byte store goes to READ.
- READ: memAddress=addr[5:2]. Next state is MERGE for a byte store, DONE for a load. On the READ→DONE transition, respData is loaded from memData in the intervening cycle.
  - Load sequencing is READ, CAPT, DONE, where CAPT is a sub-state of MERGE with the same encoding rule. At the end of CAPT, respData is loaded from memData.
  - Word load: respData = memData.
  - Byte load: lane k = addr[1:0] is bits [8k+7:8k], little-endian. The byte is placed in bits [7:0] and bits [31:8] are filled with the lane's bit 7 if signed, else 0.
- MERGE (byte store): register memData with lane addr[1:0] replaced by data[7:0]; the other three lanes are unchanged. Next state is WRITE.
- WRITE: memAddress=addr[5:2], memWriteData=the registered word (store data, or the merged word), memWriteEnable=1 for exactly this cycle. The memory commits on the negedge inside the cycle. Next state is DONE.
- DONE: respValid=1 for one cycle, respError as latched. Next state is IDLE. reqReady=0, so reqValid in DONE is ignored.
- respData changes only on load completion and holds through stores and errors.
- memAddress holds its last value when idle. memWriteEnable=0 in every state except WRITE.

## Timing
- Acceptance at edge E0; latencies are counted from E0 to the first cycle with respValid=1:
  - misaligned word: 1 cycle
  - word store: 2 cycles (WRITE, DONE)
  - load: 3 cycles (READ, CAPT, DONE)
  - byte store: 4 cycles (READ, MERGE, WRITE, DONE)
- Maximum throughput is one request per latency+1 cycles, because IDLE is revisited between requests.
- Reset values: state IDLE, respValid=0, respError=0, respData=0, memAddress=0, memWriteEnable=0, memWriteData=0.
- reqReady is forced to 0 while rst=1.
- memWriteEnable is combinationally gated by !rst. If rst is high during WRITE, no memory write occurs; the unit returns to IDLE at that edge and no respValid is issued for the aborted request.
- Every reqAddr value is legal for range; the word index is addr[5:2] with no wrap logic. Bytes at addresses 60–63 map to word 15.
- Outputs to memory come from registers; there is no combinational path from reqValid to memWriteEnable.

## Test plan
- Word store then load: store addr 0x08 data 0xDEADBEEF → WRITE cycle with memAddress=2 and memWriteEnable=1, respValid 2 cycles after acceptance. Load addr 0x08 → respData=0xDEADBEEF, respValid 3 cycles after acceptance.
- Byte store merge: word 2 holds 0x11223344; byte store addr 0x09 data 0xAA → word load returns 0x1122AA44, and exactly one memWriteEnable pulse is seen.
- Byte load extension: word 3 holds 0x80FF7F01. Load addr 0x0E signed → 0xFFFFFFFF; addr 0x0F unsigned → 0x00000080; addr 0x0F signed → 0xFFFFFF80.
- Misaligned word load at addr 0x05 → respValid and respError=1 one cycle after acceptance, memWriteEnable never asserted, respData unchanged.
- rst asserted during the WRITE cycle of a store to word 4 (old value 0x0) → word 4 stays 0x0, no respValid, reqReady=1 the cycle after rst deasserts.
- reqValid held high with three queued requests → each is accepted only in IDLE, responses arrive in order, and no request is dropped or duplicated.
